// File: rtl/sync_align_pkg.sv
// Shared definitions for the VGA control-bundle delay aligner.
package sync_align_pkg;

    localparam int SYNC_IDX_HS    = 0;
    localparam int SYNC_IDX_VS    = 1;
    localparam int SYNC_IDX_BLANK = 2;

    localparam logic [2:0] SYNC_IDLE_LEVEL = 3'b011;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } sync_state_e;

    function automatic int unsigned sync_clamp(input int unsigned req,
                                               input int unsigned max_d);
        if (req == 0)
            return 1;
        if (req > max_d)
            return max_d;
        return req;
    endfunction

endpackage

// File: rtl/sync_delay_ram.sv
// Circular history buffer: written every cycle, read combinationally by index.
module sync_delay_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_delay_aligner.sv
// Programmable hsync/vsync/blank delay line with flush/refill on reconfig.
// Define SYNC_ALIGN_FRAME_LOCK_EN to defer new delays to a vsync falling edge.
module sync_delay_aligner
    import sync_align_pkg::*;
#(
    parameter int              MAX_DELAY     = 16,
    parameter int              DW            = 3,
    parameter int              DEFAULT_DELAY = 4,
    parameter logic [DW-1:0]   IDLE_LEVEL    = SYNC_IDLE_LEVEL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DW-1:0]                sig_in,
    input  logic [$clog2(MAX_DELAY):0]   cfg_delay,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    output logic [DW-1:0]                sig_out,
    output logic                         out_valid,
    output logic [$clog2(MAX_DELAY):0]   cur_delay
);

    localparam int AW = $clog2(MAX_DELAY);
    localparam int CW = AW + 1;

    sync_state_e   state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_idx;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] cfg_clamped;
    logic [DW-1:0] rd_data;
    logic          apply;
    logic [CW-1:0] new_delay;

    assign cfg_clamped = CW'(sync_clamp(32'(cfg_delay), MAX_DELAY));

    // Natural wrap also covers cur_delay == MAX_DELAY (reads the slot being overwritten).
    assign rd_idx = wr_ptr - cur_delay[AW-1:0];

    sync_delay_ram #(
        .DEPTH (MAX_DELAY),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .waddr (wr_ptr),
        .wdata (sig_in),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

`ifdef SYNC_ALIGN_FRAME_LOCK_EN
    logic          pending;
    logic [CW-1:0] pend_delay;
    logic          vs_prev;
    logic          vs_fall;

    assign cfg_ready = (state == RUN) && !pending;
    assign apply     = pending && vs_fall;
    assign new_delay = pend_delay;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= 1'b0;
            pend_delay <= '0;
            vs_prev    <= 1'b0;
            vs_fall    <= 1'b0;
        end else begin
            vs_prev <= sig_in[SYNC_IDX_VS];
            vs_fall <= vs_prev && !sig_in[SYNC_IDX_VS];
            if (cfg_valid && cfg_ready) begin
                pending    <= 1'b1;
                pend_delay <= cfg_clamped;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end
`else
    assign cfg_ready = (state == RUN);
    assign apply     = cfg_valid && cfg_ready;
    assign new_delay = cfg_clamped;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            cur_delay <= CW'(DEFAULT_DELAY);
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            sig_out   <= IDLE_LEVEL;
            out_valid <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + 1'b1;
            if (apply) begin
                cur_delay <= new_delay;
                fill_cnt  <= '0;
                state     <= FILL;
                sig_out   <= IDLE_LEVEL;
                out_valid <= 1'b0;
            end else begin
                unique case (state)
                    FILL: begin
                        if (fill_cnt == cur_delay - CW'(1)) begin
                            state     <= RUN;
                            sig_out   <= rd_data;
                            out_valid <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        sig_out <= rd_data;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_delay_aligner.sv
// Randomized bench for sync_delay_aligner against an edge-indexed history model.
module tb_sync_delay_aligner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sig_in = '0;
    logic [4:0] cfg_delay = '0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] sig_out;
    logic       out_valid;
    logic [4:0] cur_delay;

    int checks = 0;
    int errors = 0;

    // Model: n = edges since reset release, hist[i] = sig_in at edge i+1.
    int         n;
    int         d;
    int         valid_from;
    logic       exp_valid;
    logic       last_accept;
    logic [2:0] hist[$];

    always #5 clk = ~clk;

    sync_delay_aligner dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .cfg_delay (cfg_delay),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .sig_out   (sig_out),
        .out_valid (out_valid),
        .cur_delay (cur_delay)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n          = 0;
        d          = 4;
        valid_from = 4;
        exp_valid  = 1'b0;
        hist.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sig_out"}, 32'(sig_out), 32'h3);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, "_cur_delay"}, 32'(cur_delay), 32'd4);
    endtask

    task automatic step(input logic [2:0] s, input logic cv, input logic [4:0] cd);
        int req;
        sig_in    = s;
        cfg_valid = cv;
        cfg_delay = cd;
        last_accept = cv && exp_valid;
        @(posedge clk);
        #1;
        n++;
        hist.push_back(s);
        if (last_accept) begin
            req = int'(cd);
            d = (req == 0) ? 1 : ((req > 16) ? 16 : req);
            valid_from = n + d;
        end
        exp_valid = (n >= valid_from);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("cfg_ready", 32'(cfg_ready), 32'(exp_valid));
        chk("cur_delay", 32'(cur_delay), 32'(d));
        if (!exp_valid)
            chk("sig_out_idle", 32'(sig_out), 32'h3);
        else if (n - d >= 1)
            chk("sig_out_data", 32'(sig_out), 32'(hist[n - d - 1]));
    endtask

    task automatic run_rand(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(3'($urandom), 1'b0, 5'($urandom));
    endtask

    task automatic pulse_reset(input string tag);
        #3 rst = 1'b1;
        #1 chk_reset_vals(tag);
        #1 rst = 1'b0;
        cfg_valid = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #12;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Counting pattern from reset: valid on the 4th edge.
        for (int i = 0; i < 20; i++)
            step(3'(i), 1'b0, 5'd0);

        // Reprogram to 9 for one cycle.
        step(3'($urandom), 1'b1, 5'd9);
        run_rand(30);

        // Clamp low, then clamp high with several pointer wraps.
        step(3'($urandom), 1'b1, 5'd0);
        run_rand(20);
        step(3'($urandom), 1'b1, 5'd31);
        run_rand(70);

        // Request held through FILL is taken on the first RUN cycle.
        step(3'($urandom), 1'b1, 5'd5);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                step(3'($urandom), 1'b1, 5'd7);
                got = last_accept;
            end
            chk("held_cfg_accepted", 32'(got), 32'd1);
        end
        run_rand(20);

        // Random reconfiguration traffic.
        for (int i = 0; i < 300; i++)
            step(3'($urandom), ($urandom_range(0, 15) == 0), 5'($urandom));

        // Async reset mid-RUN, then mid-FILL.
        step(3'($urandom), 1'b1, 5'd3);
        run_rand(10);
        pulse_reset("rst_run");
        run_rand(2);
        pulse_reset("rst_fill");
        run_rand(25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
